hwpe_stream_tcdm_responder: RTL and testbench

//  TCDM slave (responder) end of the hwpe_stream TCDM protocol: a single-port word memory that

---
 rtl/hwpe_stream_tcdm_responder_if.sv | 22 ++
 rtl/hwpe_stream_tcdm_responder.sv | 127 ++++++++++++
 tb/tb_hwpe_stream_tcdm_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_tcdm_responder_if.sv
// TCDM request/response bundle between a streamer master and a memory responder.
// The master drives the request fields; the responder drives the grant and response.
interface hwpe_stream_tcdm_responder_if;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (
        output req, add, wen, be, data,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt, r_data, r_valid
    );
endinterface

// File: rtl/hwpe_stream_tcdm_responder.sv
// TCDM word memory answering req/gnt/r_valid transactions, with a fixed response
// latency and an optional periodic grant stall.
module hwpe_stream_tcdm_responder #(
    parameter int unsigned NB_WORDS     = 1024,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STALL_PERIOD = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clear_i,
    hwpe_stream_tcdm_responder_if.slave        tcdm,
    output logic                               err_o
);
    localparam int unsigned AW       = $clog2(NB_WORDS);
    localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

    logic          accept;
    logic          in_range;
    logic [AW-1:0] index;
    logic          wr_en;
    logic          rd_en;
    logic [3:0]    byte_we;
    logic          unused_addr_bits;

    logic [31:0]        mem_q [NB_WORDS];
    logic [31:0]        rd_word_q;
    logic               rd_read_q;
    logic               rd_oob_q;
    logic [LATENCY-1:0] valid_q;
    logic               err_q;
    logic [31:0]        stage0_data;

    assign accept           = tcdm.req & tcdm.gnt;
    // Full 30-bit word index is compared, so high address bits can never alias into range.
    assign in_range         = ({2'b00, tcdm.add[31:2]} < 32'(NB_WORDS));
    assign index            = tcdm.add[AW+1:2];
    assign wr_en            = accept & ~tcdm.wen & in_range;
    assign rd_en            = accept & tcdm.wen & in_range;
    assign unused_addr_bits = ^tcdm.add[1:0];

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
        assign byte_we[gi] = wr_en & tcdm.be[gi];
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_we[i]) begin
                mem_q[index][i*8 +: 8] <= tcdm.data[i*8 +: 8];
            end
        end
        if (rd_en) begin
            rd_word_q <= mem_q[index];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_read_q <= 1'b0;
            rd_oob_q  <= 1'b0;
            valid_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rd_read_q <= accept & tcdm.wen;
            rd_oob_q  <= ~in_range;
            // Clear drops in-flight responses, including one accepted this very cycle.
            if (clear_i) begin
                valid_q <= '0;
                err_q   <= 1'b0;
            end else begin
                valid_q <= (valid_q << 1) | LATENCY'(accept);
                err_q   <= err_q | (accept & ~in_range);
            end
        end
    end

    assign stage0_data  = rd_read_q ? (rd_oob_q ? OOR_DATA : rd_word_q) : 32'h0;
    assign tcdm.r_valid = valid_q[LATENCY-1];
    assign err_o        = err_q;

    if (LATENCY == 1) begin : g_lat1
        assign tcdm.r_data = stage0_data;
    end else begin : g_latn
        logic [31:0] data_q [LATENCY-1];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < LATENCY-1; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                data_q[0] <= stage0_data;
                for (int i = 1; i < LATENCY-1; i++) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end

        assign tcdm.r_data = data_q[LATENCY-2];
    end

    if (STALL_PERIOD == 0) begin : g_no_stall
        assign tcdm.gnt = 1'b1;
    end else begin : g_stall
        localparam int unsigned CW = $clog2(STALL_PERIOD);
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(STALL_PERIOD-1)) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else if (clear_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign tcdm.gnt = (cnt_q != CW'(STALL_PERIOD-1));
    end
endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// Directed bench: four responder configurations share one request stream; each
// test inspects the instance whose latency/stall setting it targets.
module tb_hwpe_stream_tcdm_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clear;
    logic        req;
    logic        wen;
    logic [31:0] add;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err_a, err_b, err_c, err_d;

    hwpe_stream_tcdm_responder_if if_a ();
    hwpe_stream_tcdm_responder_if if_b ();
    hwpe_stream_tcdm_responder_if if_c ();
    hwpe_stream_tcdm_responder_if if_d ();

    assign if_a.req = req; assign if_a.wen = wen; assign if_a.add = add; assign if_a.be = be; assign if_a.data = wdata;
    assign if_b.req = req; assign if_b.wen = wen; assign if_b.add = add; assign if_b.be = be; assign if_b.data = wdata;
    assign if_c.req = req; assign if_c.wen = wen; assign if_c.add = add; assign if_c.be = be; assign if_c.data = wdata;
    assign if_d.req = req; assign if_d.wen = wen; assign if_d.add = add; assign if_d.be = be; assign if_d.data = wdata;

    hwpe_stream_tcdm_responder #(.NB_WORDS(16), .LATENCY(1), .STALL_PERIOD(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm(if_a), .err_o(err_a));
    hwpe_stream_tcdm_responder #(.NB_WORDS(16), .LATENCY(3), .STALL_PERIOD(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm(if_b), .err_o(err_b));
    hwpe_stream_tcdm_responder #(.NB_WORDS(16), .LATENCY(1), .STALL_PERIOD(4)) dut_c (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm(if_c), .err_o(err_c));
    hwpe_stream_tcdm_responder #(.NB_WORDS(16), .LATENCY(4), .STALL_PERIOD(0)) dut_d (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm(if_d), .err_o(err_d));

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] data;
    } rsp_t;

    rsp_t qa[$];
    rsp_t qb[$];
    rsp_t qc[$];
    rsp_t qd[$];
    int   cyc = 0;
    int   last_edge;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response log: cycle stamp is the number of rising edges seen so far.
    always @(negedge clk) begin
        if (if_a.r_valid) qa.push_back(rsp_t'{32'(cyc), if_a.r_data});
        if (if_b.r_valid) qb.push_back(rsp_t'{32'(cyc), if_b.r_data});
        if (if_c.r_valid) qc.push_back(rsp_t'{32'(cyc), if_c.r_data});
        if (if_d.r_valid) qd.push_back(rsp_t'{32'(cyc), if_d.r_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic op(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; wen = w; add = a; be = b; wdata = d;
        last_edge = cyc + 1;
        $display("op %s add=0x%08h be=%b data=0x%08h edge=%0d", w ? "RD" : "WR", a, b, d, last_edge);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1;
        logic [11:0] low_mask;

        rst = 1'b1; clear = 1'b0; req = 1'b0; wen = 1'b1; add = '0; be = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_rvalid_a", 32'(if_a.r_valid), 32'h0);
        check("rst_rdata_a", if_a.r_data, 32'h0);
        check("rst_err_a", 32'(err_a), 32'h0);
        check("rst_gnt_c", 32'(if_c.gnt), 32'h1);
        check("rst_rdata_d", if_d.r_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read, latency 1
        idle(2);
        qa.delete();
        op(1'b0, 32'h10, 4'hF, 32'hCAFEBABE); e0 = last_edge;
        op(1'b1, 32'h10, 4'h0, 32'h0);        e1 = last_edge;
        idle(5);
        check("t1_count", qa.size(), 32'd2);
        if (qa.size() >= 2) begin
            check("t1_wr_cyc", qa[0].cyc, 32'(e0));
            check("t1_wr_data", qa[0].data, 32'h0);
            check("t1_rd_cyc", qa[1].cyc, 32'(e1));
            check("t1_rd_data", qa[1].data, 32'hCAFEBABE);
        end

        // Byte enables and read-after-write
        qa.delete();
        op(1'b0, 32'h20, 4'hF, 32'hFFFFFFFF);
        op(1'b0, 32'h20, 4'b0101, 32'h00000000);
        op(1'b1, 32'h20, 4'h0, 32'h0);
        op(1'b0, 32'h20, 4'h0, 32'h12345678);
        op(1'b1, 32'h20, 4'h0, 32'h0);
        idle(5);
        check("t2_count", qa.size(), 32'd5);
        if (qa.size() >= 5) begin
            check("t2_be0101", qa[2].data, 32'hFF00FF00);
            check("t2_be0000", qa[4].data, 32'hFF00FF00);
        end

        // Latency 3, eight back-to-back reads
        for (int i = 0; i < 8; i++) op(1'b0, 32'(i * 4), 4'hF, 32'h1000 + 32'(i * 'h11));
        idle(6);
        qb.delete();
        for (int i = 0; i < 8; i++) begin
            op(1'b1, 32'(i * 4), 4'h0, 32'h0);
            if (i == 0) e0 = last_edge;
        end
        idle(10);
        check("t3_count", qb.size(), 32'd8);
        if (qb.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t3_cyc%0d", i), qb[i].cyc, 32'(e0 + 2 + i));
                check($sformatf("t3_data%0d", i), qb[i].data, 32'h1000 + 32'(i * 'h11));
            end
        end

        // Out-of-range accesses and sticky error
        qa.delete();
        check("t5_err_pre", 32'(err_a), 32'h0);
        op(1'b1, 32'h40, 4'h0, 32'h0);
        op(1'b1, 32'h10, 4'h0, 32'h0);
        op(1'b0, 32'h40, 4'hF, 32'h55555555);
        op(1'b1, 32'h00, 4'h0, 32'h0);
        op(1'b1, 32'h100, 4'h0, 32'h0);
        op(1'b1, 32'h80000010, 4'h0, 32'h0);
        idle(5);
        check("t5_count", qa.size(), 32'd6);
        if (qa.size() >= 6) begin
            check("t5_oor_rd", qa[0].data, 32'hDEADBEEF);
            check("t5_inrange_rd", qa[1].data, 32'h1044);
            check("t5_oor_wr_rsp", qa[2].data, 32'h0);
            check("t5_no_alias", qa[3].data, 32'h1000);
            check("t5_oor_idx64", qa[4].data, 32'hDEADBEEF);
            check("t5_oor_highbit", qa[5].data, 32'hDEADBEEF);
        end
        check("t5_err_sticky", 32'(err_a), 32'h1);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("t5_err_cleared", 32'(err_a), 32'h0);

        // Grant stall every 4 cycles with req held for 12 cycles
        idle(5);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        qc.delete();
        req = 1'b1; wen = 1'b1; add = 32'h0;
        low_mask = '0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (!if_c.gnt) low_mask[k] = 1'b1;
        end
        @(negedge clk); req = 1'b0;
        idle(5);
        check("t4_gnt_low_mask", 32'(low_mask), 32'h888);
        check("t4_rvalid_count", qc.size(), 32'd9);

        // Latency 4: clear with three in flight
        idle(6);
        qd.delete();
        op(1'b1, 32'h4, 4'h0, 32'h0);
        op(1'b1, 32'h8, 4'h0, 32'h0);
        op(1'b1, 32'hC, 4'h0, 32'h0);
        @(negedge clk); req = 1'b0; clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        idle(8);
        check("t6_clear_drop", qd.size(), 32'd0);

        // Accept during clear: write lands in memory, response dropped
        @(negedge clk);
        req = 1'b1; wen = 1'b0; add = 32'h8; be = 4'hF; wdata = 32'hABCD0123; clear = 1'b1;
        @(negedge clk); clear = 1'b0; req = 1'b0;
        idle(8);
        check("t6_clear_acc_drop", qd.size(), 32'd0);
        op(1'b1, 32'h4, 4'h0, 32'h0); e0 = last_edge;
        op(1'b1, 32'h8, 4'h0, 32'h0);
        idle(8);
        check("t6_post_clear_count", qd.size(), 32'd2);
        if (qd.size() >= 2) begin
            check("t6_post_clear_cyc", qd[0].cyc, 32'(e0 + 3));
            check("t6_mem_kept", qd[0].data, 32'h1011);
            check("t6_clear_wr_done", qd[1].data, 32'hABCD0123);
        end

        // Latency 4: reset with three in flight
        qd.delete();
        op(1'b1, 32'h4, 4'h0, 32'h0);
        op(1'b1, 32'h8, 4'h0, 32'h0);
        op(1'b1, 32'hC, 4'h0, 32'h0);
        @(negedge clk); req = 1'b0; rst = 1'b1;
        #1;
        check("t6_rst_rvalid", 32'(if_d.r_valid), 32'h0);
        check("t6_rst_rdata", if_d.r_data, 32'h0);
        @(negedge clk); rst = 1'b0;
        idle(8);
        check("t6_rst_drop", qd.size(), 32'd0);
        op(1'b1, 32'h4, 4'h0, 32'h0); e0 = last_edge;
        idle(8);
        check("t6_post_rst_count", qd.size(), 32'd1);
        if (qd.size() >= 1) check("t6_post_rst_cyc", qd[0].cyc, 32'(e0 + 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
